// File: rtl/diff_addr_seq.sv
// Address sequencer for finite-difference sweeps: walks a frame-major buffer in
// ascending order and emits each element's forward neighbour on the chosen axis.
module diff_addr_seq #(
  parameter int ADDR_W    = 8,
  parameter int ROW_WORDS = 4,
  parameter int ROWS      = 4,
  parameter int FRAMES_W  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [FRAMES_W-1:0] f_num,
  input  logic                en,
  output logic                busy,
  output logic [ADDR_W-1:0]   addr,
  output logic [ADDR_W-1:0]   nbr_addr,
  output logic                addr_vld,
  output logic                seg_start,
  output logic                last,
  output logic                done
);

  localparam int CW = $clog2(ROW_WORDS);
  localparam int RW = $clog2(ROWS);

  if (ADDR_W < $clog2(((2 ** FRAMES_W) - 1) * ROWS * ROW_WORDS)) begin : g_addr_w_check
    $error("diff_addr_seq: ADDR_W too small for the largest frame count");
  end
  if (ROW_WORDS < 2 || ROWS < 2) begin : g_dim_check
    $error("diff_addr_seq: ROW_WORDS and ROWS must be at least 2");
  end

  localparam logic [CW-1:0]     COL_MAX  = CW'(ROW_WORDS - 1);
  localparam logic [RW-1:0]     ROW_MAX  = RW'(ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_SZ   = ADDR_W'(ROW_WORDS);
  localparam logic [ADDR_W-1:0] FRAME_SZ = ADDR_W'(ROWS * ROW_WORDS);
  localparam logic [ADDR_W-1:0] DX_WRAP  = ADDR_W'(ROW_WORDS - 1);
  localparam logic [ADDR_W-1:0] DY_WRAP  = ADDR_W'((ROWS - 1) * ROW_WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_n;
  logic [1:0]          mode_q;
  logic [FRAMES_W-1:0] f_max;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [FRAMES_W-1:0] frm;
  logic [ADDR_W-1:0]   cur;
  logic [ADDR_W-1:0]   fbase;
  logic                fin;

  logic                beat;
  logic                at_end;
  logic [ADDR_W-1:0]   nbr_n;
  logic                seg_n;

  // The scan stays in RUN for the cycle that presents the final beat (fin set),
  // so busy drops exactly when done rises.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (fin) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    beat   = (state == RUN) && !fin && en;
    at_end = (col == COL_MAX) && (row == ROW_MAX) && (frm == f_max);
    nbr_n  = '0;
    seg_n  = 1'b0;
    case (mode_q)
      2'd1: begin
        nbr_n = (row == ROW_MAX) ? cur - DY_WRAP : cur + ROW_SZ;
        seg_n = (row == '0) && (col == '0);
      end
      2'd2: begin
        nbr_n = (frm == f_max) ? cur - fbase : cur + FRAME_SZ;
        seg_n = (cur == '0);
      end
      default: begin
        nbr_n = (col == COL_MAX) ? cur - DX_WRAP : cur + ADDR_W'(1);
        seg_n = (col == '0);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr      <= '0;
      nbr_addr  <= '0;
      addr_vld  <= 1'b0;
      seg_start <= 1'b0;
      last      <= 1'b0;
      mode_q    <= '0;
      f_max     <= '0;
      col       <= '0;
      row       <= '0;
      frm       <= '0;
      cur       <= '0;
      fbase     <= '0;
      fin       <= 1'b0;
    end else begin
      state     <= state_n;
      busy      <= (state_n == RUN);
      done      <= (state_n == DONE);
      addr_vld  <= beat;
      seg_start <= beat && seg_n;
      last      <= beat && at_end;

      if (state == IDLE && start) begin
        mode_q <= mode;
        f_max  <= (f_num == '0) ? '0 : f_num - FRAMES_W'(1);
        col    <= '0;
        row    <= '0;
        frm    <= '0;
        cur    <= '0;
        fbase  <= '0;
        fin    <= 1'b0;
      end

      if (beat) begin
        addr     <= cur;
        nbr_addr <= nbr_n;
        cur      <= cur + ADDR_W'(1);
        if (at_end) fin <= 1'b1;
        if (col == COL_MAX) begin
          col <= '0;
          if (row == ROW_MAX) begin
            row   <= '0;
            frm   <= frm + FRAMES_W'(1);
            fbase <= fbase + FRAME_SZ;
          end else begin
            row <= row + RW'(1);
          end
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_diff_addr_seq.sv
// Scoreboard bench for diff_addr_seq at default geometry (4x4 words per frame).
module tb_diff_addr_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] f_num = 2'd1;
  logic       en = 1'b0;
  logic       busy, addr_vld, seg_start, last, done;
  logic [7:0] addr, nbr_addr;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] n;
    logic       s;
    logic       l;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    passes = 0;

  diff_addr_seq #(.ADDR_W(8), .ROW_WORDS(4), .ROWS(4), .FRAMES_W(2)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .f_num(f_num), .en(en),
    .busy(busy), .addr(addr), .nbr_addr(nbr_addr), .addr_vld(addr_vld),
    .seg_start(seg_start), .last(last), .done(done)
  );

  always #5 clk = ~clk;

  // Independent model of beat k for a given axis and frame count.
  function automatic beat_t model(input int k, input int md, input int nf);
    beat_t b;
    int c, r, f, n;
    c = k % 4;
    r = (k / 4) % 4;
    f = k / 16;
    if (md == 1) n = f * 16 + ((r + 1) % 4) * 4 + c;
    else if (md == 2) n = ((f + 1) % nf) * 16 + r * 4 + c;
    else n = f * 16 + r * 4 + (c + 1) % 4;
    b.a = 8'(k);
    b.n = 8'(n);
    b.s = (md == 1) ? (r == 0 && c == 0) : (md == 2) ? (k == 0) : (c == 0);
    b.l = (k == nf * 16 - 1);
    return b;
  endfunction

  function automatic logic en_pat(input int sel, input int cyc);
    if (sel == 1) return !((cyc >= 8 && cyc < 10) || (cyc >= 15 && cyc < 17));
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, addr, nbr_addr, addr_vld, seg_start, last, done} !== 22'd0)
      $display("FAIL reset_outputs got busy=%b addr=%0d nbr=%0d vld=%b seg=%b last=%b done=%b want all 0",
               busy, addr, nbr_addr, addr_vld, seg_start, last, done);
    else passes++;
    rst = 1'b0; start = 1'b0; en = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle busy=%b want 0", busy);
    else passes++;
  endtask

  // Runs one full scan; poke=1 pulses start mid-run with other settings.
  task automatic test_scan(input string name, input int md, input int fn, input int pat, input bit poke);
    int nf, total, k, seen, cyc;
    beat_t e;
    nf = (fn == 0) ? 1 : fn;
    total = nf * 16;
    k = 0; seen = 0; cyc = 0;
    q.delete();
    mode = 2'(md); f_num = 2'(fn); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) $display("FAIL %s_busy got %b want 1", name, busy);
    else passes++;
    while (seen < total && cyc < 400) begin
      en = en_pat(pat, cyc);
      if (poke) begin
        start = (cyc == 3);
        mode = (cyc == 3) ? 2'd2 : 2'(md);
        f_num = (cyc == 3) ? 2'd3 : 2'(fn);
      end
      if (en && k < total) begin
        q.push_back(model(k, (md == 3) ? 0 : md, nf));
        k++;
      end
      @(negedge clk);
      cyc++;
      if (addr_vld) begin
        checks++;
        if (q.size() == 0) begin
          $display("FAIL %s_extra_beat addr=%0d want no beat", name, addr);
        end else begin
          e = q.pop_front();
          seen++;
          if (addr !== e.a || nbr_addr !== e.n || seg_start !== e.s || last !== e.l)
            $display("FAIL %s_beat got addr=%0d nbr=%0d seg=%b last=%b want addr=%0d nbr=%0d seg=%b last=%b",
                     name, addr, nbr_addr, seg_start, last, e.a, e.n, e.s, e.l);
          else passes++;
        end
      end else begin
        checks++;
        if (seg_start !== 1'b0 || last !== 1'b0 || done !== 1'b0)
          $display("FAIL %s_idle_flags got seg=%b last=%b done=%b want 0 0 0", name, seg_start, last, done);
        else passes++;
      end
    end
    start = 1'b0; en = 1'b0; mode = 2'(md); f_num = 2'(fn);
    checks++;
    if (seen !== total || q.size() != 0)
      $display("FAIL %s_beat_count got %0d want %0d", name, seen, total);
    else passes++;
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || addr_vld !== 1'b0)
      $display("FAIL %s_done got done=%b busy=%b vld=%b want 1 0 0", name, done, busy, addr_vld);
    else passes++;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s_done_pulse got done=%b busy=%b want 0 0", name, done, busy);
    else passes++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL %s_start_in_done busy=%b want 0", name, busy);
    else passes++;
  endtask

  task automatic test_abort();
    int seen, cyc, k;
    beat_t e;
    seen = 0; cyc = 0; k = 0;
    q.delete();
    mode = 2'd0; f_num = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (seen < 10 && cyc < 100) begin
      en = 1'b1;
      if (k < 10) begin
        q.push_back(model(k, 0, 1));
        k++;
      end else en = 1'b0;
      @(negedge clk);
      cyc++;
      if (addr_vld) begin
        checks++;
        e = q.pop_front();
        seen++;
        if (addr !== e.a || nbr_addr !== e.n)
          $display("FAIL abort_pre got addr=%0d nbr=%0d want %0d %0d", addr, nbr_addr, e.a, e.n);
        else passes++;
      end
    end
    rst = 1'b1; en = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; en = 1'b0; start = 1'b0;
    checks++;
    if ({busy, addr, nbr_addr, addr_vld, seg_start, last, done} !== 22'd0)
      $display("FAIL abort_reset got busy=%b addr=%0d vld=%b done=%b want all 0", busy, addr, addr_vld, done);
    else passes++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL abort_no_done got done=%b busy=%b want 0 0", done, busy);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_scan("dx", 0, 1, 0, 1'b0);
    test_scan("dy", 1, 2, 0, 1'b0);
    test_scan("dt", 2, 3, 0, 1'b0);
    test_scan("dx_en_gaps", 0, 1, 1, 1'b0);
    test_scan("mode3_busy_start", 3, 1, 0, 1'b1);
    test_abort();
    test_scan("restart", 0, 1, 0, 1'b0);
    test_scan("fnum0", 0, 0, 1, 1'b0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
